// File: rtl/pipelined_add_sub.sv
// Pipelined two's-complement adder/subtractor with a valid/ready handshake.
// WIDTH is split into STAGES chunks of C bits each. Stage k resolves the carry
// of chunk k, so a result appears STAGES cycles after its operands are accepted.
// Each beat carries its operands, its partial sum and its running carry along
// the pipe. A stage is free to load when it is empty or when its beat moves on,
// so an empty slot is filled even while the output is stalled.
module pipelined_add_sub #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned C = WIDTH / STAGES;

    // Per-stage state: valid, operand A, operand B' (already inverted for sub),
    // partial sum (chunks 0..k resolved) and carry out of chunk k.
    logic             r_v [STAGES];
    logic [WIDTH-1:0] r_a [STAGES];
    logic [WIDTH-1:0] r_b [STAGES];
    logic [WIDTH-1:0] r_s [STAGES];
    logic             r_c [STAGES];
    logic             r_ovf;

    // Per-stage load inputs and next-state values.
    logic [STAGES-1:0] w_rdy;
    logic              w_inv [STAGES];
    logic [WIDTH-1:0]  w_ina [STAGES];
    logic [WIDTH-1:0]  w_inb [STAGES];
    logic [WIDTH-1:0]  w_ins [STAGES];
    logic              w_cin [STAGES];
    logic [C:0]        w_ck  [STAGES];
    logic [WIDTH-1:0]  w_ns  [STAGES];
    logic              w_ovf;

    // Ready chain from the output back to the input: a stage may load when it
    // is empty or when the stage after it is loading.
    always_comb begin : p_ready
        logic v_r;
        v_r   = out_ready;
        w_rdy = '0;
        for (int unsigned i = 0; i < STAGES; i++) begin
            v_r = !r_v[STAGES-1-i] || v_r;
            w_rdy[STAGES-1-i] = v_r;
        end
    end

    // Source of each stage: the input ports for stage 0, otherwise the stage before.
    always_comb begin
        w_inv[0] = in_valid;
        w_ina[0] = a;
        w_inb[0] = sub ? ~b : b;
        w_ins[0] = '0;
        w_cin[0] = sub;
        for (int unsigned k = 1; k < STAGES; k++) begin
            w_inv[k] = r_v[k-1];
            w_ina[k] = r_a[k-1];
            w_inb[k] = r_b[k-1];
            w_ins[k] = r_s[k-1];
            w_cin[k] = r_c[k-1];
        end
    end

    // Chunk adders: stage k sums chunk k and splices it into the partial sum.
    always_comb begin
        for (int unsigned k = 0; k < STAGES; k++) begin
            w_ck[k] = {1'b0, w_ina[k][k*C +: C]} + {1'b0, w_inb[k][k*C +: C]}
                    + {{C{1'b0}}, w_cin[k]};
            w_ns[k] = w_ins[k];
            w_ns[k][k*C +: C] = w_ck[k][C-1:0];
        end
    end

    // Signed overflow of the final stage: equal operand signs giving a result of
    // the other sign, equivalent to carry-into-MSB XOR carry-out-of-MSB.
    always_comb begin
        w_ovf = (w_ina[STAGES-1][WIDTH-1] == w_inb[STAGES-1][WIDTH-1]) &&
                (w_ns[STAGES-1][WIDTH-1] != w_ina[STAGES-1][WIDTH-1]);
    end

    // Stage registers: load on ready, hold otherwise; data only moves with a valid beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                r_v[k] <= 1'b0;
                r_a[k] <= '0;
                r_b[k] <= '0;
                r_s[k] <= '0;
                r_c[k] <= 1'b0;
            end
            r_ovf <= 1'b0;
        end else begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                if (w_rdy[k]) begin
                    r_v[k] <= w_inv[k];
                    if (w_inv[k]) begin
                        r_a[k] <= w_ina[k];
                        r_b[k] <= w_inb[k];
                        r_s[k] <= w_ns[k];
                        r_c[k] <= w_ck[k][C];
                    end
                end
            end
            if (w_rdy[STAGES-1] && w_inv[STAGES-1]) begin
                r_ovf <= w_ovf;
            end
        end
    end

    assign in_ready  = w_rdy[0];
    assign out_valid = r_v[STAGES-1];
    assign sum       = r_s[STAGES-1];
    assign cout      = r_c[STAGES-1];
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Testbench for pipelined_add_sub (WIDTH=32, STAGES=4).
// A negedge monitor pushes the expected result of every accepted beat onto a
// queue and pops/compares one entry for every result taken by the downstream.
module tb_pipelined_add_sub;

    localparam int unsigned W = 32;
    localparam int unsigned S = 4;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b1;
    logic         in_valid  = 1'b0;
    logic         out_ready = 1'b1;
    logic         sub       = 1'b0;
    logic [W-1:0] a         = '0;
    logic [W-1:0] b         = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int n_checks = 0;
    int n_errors = 0;
    int n_iss    = 0;
    int n_recv   = 0;
    logic [W+1:0] q[$];

    pipelined_add_sub #(.WIDTH(W), .STAGES(S)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf)
    );

    always #5 clk = ~clk;

    // Reference: {sum, cout, ovf} from wide signed/unsigned arithmetic.
    function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic s);
        longint       sx, sy, r;
        logic [W:0]   t;
        logic [W-1:0] res;
        logic         c, o;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (s) begin
            r   = sx - sy;
            res = x - y;
            c   = (x >= y);
        end else begin
            r   = sx + sy;
            t   = {1'b0, x} + {1'b0, y};
            res = t[W-1:0];
            c   = t[W];
        end
        o = (r > 64'sd2147483647) || (r < -64'sd2147483648);
        return {res, c, o};
    endfunction

    // Scoreboard monitor: results leaving are popped before new beats are pushed.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                n_checks++;
                if (q.size() == 0) begin
                    n_errors++;
                    $display("FAIL unexpected_output: got sum=%h cout=%b ovf=%b, required no result",
                             sum, cout, ovf);
                end else begin
                    logic [W+1:0] e;
                    e = q.pop_front();
                    n_recv++;
                    if ({sum, cout, ovf} !== e) begin
                        n_errors++;
                        $display("FAIL result: got sum=%h cout=%b ovf=%b, required sum=%h cout=%b ovf=%b",
                                 sum, cout, ovf, e[W+1:2], e[1], e[0]);
                    end
                end
            end
            if (in_valid && in_ready) begin
                q.push_back(model(a, b, sub));
                n_iss++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int guard;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        guard     = 0;
        while (q.size() != 0 && guard < 50) begin
            step();
            guard++;
        end
        n_checks++;
        if (q.size() != 0) begin
            n_errors++;
            $display("FAIL drain_timeout: got %0d pending, required 0", q.size());
            q.delete();
        end
        step();
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({out_valid, in_ready, sum, cout, ovf} !== {1'b0, 1'b1, {W{1'b0}}, 1'b0, 1'b0}) begin
            n_errors++;
            $display("FAIL reset_async: got ov=%b ir=%b sum=%h c=%b o=%b, required 0 1 0 0 0",
                     out_valid, in_ready, sum, cout, ovf);
        end
        step();
        step();
        rst_n = 1'b1;
        step();
        n_checks++;
        if ({out_valid, in_ready, sum} !== {1'b0, 1'b1, {W{1'b0}}}) begin
            n_errors++;
            $display("FAIL reset_release: got ov=%b ir=%b sum=%h, required 0 1 0",
                     out_valid, in_ready, sum);
        end
    endtask

    task automatic test_directed();
        logic [W-1:0] da[3] = '{32'h7FFFFFFF, 32'd5, 32'd0};
        logic [W-1:0] db[3] = '{32'd1, 32'd7, 32'h80000000};
        logic         ds[3] = '{1'b0, 1'b1, 1'b1};
        out_ready = 1'b1;
        step();
        a = 32'hFFFFFFFF; b = 32'd1; sub = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int j = 1; j <= 4; j++) begin
            if (j > 1) step();
            n_checks++;
            if (out_valid !== (j == 4)) begin
                n_errors++;
                $display("FAIL latency: edge %0d got out_valid=%b, required %b", j, out_valid, j == 4);
            end
        end
        n_checks++;
        if ({sum, cout, ovf} !== {32'h0, 1'b1, 1'b0}) begin
            n_errors++;
            $display("FAIL carry_chain: got sum=%h c=%b o=%b, required 00000000 1 0", sum, cout, ovf);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            a = da[i]; b = db[i]; sub = ds[i]; in_valid = 1'b1;
        end
        step();
        in_valid = 1'b0;
        drain();
    endtask

    // Common stream driver: holds a beat until accepted, checks in_ready against
    // occupancy (ready iff downstream ready or some stage free).
    task automatic test_stream();
        int  sent = 0;
        int  c    = 0;
        logic acc = 1'b0;
        out_ready = 1'b1;
        while (sent < 100 && c < 400) begin
            step();
            if (acc) sent++;
            if (sent < 100) begin
                if (!in_valid || acc) begin
                    a = $urandom; b = $urandom; sub = 1'($urandom_range(0, 1));
                end
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #2;
            n_checks++;
            if (in_ready !== 1'b1) begin
                n_errors++;
                $display("FAIL stream_in_ready: cycle %0d got %b, required 1", c, in_ready);
            end
            n_checks++;
            if (out_valid !== (c >= 4)) begin
                n_errors++;
                $display("FAIL stream_out_valid: cycle %0d got %b, required %b", c, out_valid, c >= 4);
            end
            acc = in_valid && in_ready;
            c++;
        end
        drain();
    endtask

    task automatic test_stall();
        int           sent = 0;
        logic         acc  = 1'b0;
        logic [W-1:0] fsum = '0;
        for (int c = 0; c < 60 && sent < 30; c++) begin
            step();
            if (acc) sent++;
            out_ready = !(c >= 6 && c < 16);
            if (sent < 30) begin
                if (!in_valid || acc) begin
                    a = $urandom; b = $urandom; sub = 1'($urandom_range(0, 1));
                end
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #2;
            n_checks++;
            if (in_ready !== (out_ready || (q.size() < S))) begin
                n_errors++;
                $display("FAIL stall_in_ready: cycle %0d got %b, required %b", c, in_ready,
                         out_ready || (q.size() < S));
            end
            if (c == 6) fsum = sum;
            if (c >= 6 && c < 16) begin
                n_checks++;
                if ({out_valid, in_ready, sum} !== {1'b1, 1'b0, fsum}) begin
                    n_errors++;
                    $display("FAIL stall_frozen: cycle %0d got ov=%b ir=%b sum=%h, required 1 0 %h",
                             c, out_valid, in_ready, sum, fsum);
                end
            end
            acc = in_valid && in_ready;
        end
        drain();
    endtask

    task automatic test_sparse();
        int   issued = 0;
        int   r0;
        logic acc    = 1'b0;
        r0 = n_recv;
        for (int c = 0; c < 90; c++) begin
            step();
            if (acc) issued++;
            out_ready = 1'($urandom_range(0, 1));
            if (in_valid && !acc) begin
                in_valid = 1'b1;
            end else if (c % 3 == 0) begin
                a = $urandom; b = $urandom; sub = 1'($urandom_range(0, 1));
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #2;
            n_checks++;
            if (in_ready !== (out_ready || (q.size() < S))) begin
                n_errors++;
                $display("FAIL sparse_in_ready: cycle %0d got %b, required %b", c, in_ready,
                         out_ready || (q.size() < S));
            end
            acc = in_valid && in_ready;
        end
        step();
        if (acc) issued++;
        drain();
        n_checks++;
        if (n_recv - r0 !== issued) begin
            n_errors++;
            $display("FAIL sparse_count: got %0d received, required %0d issued", n_recv - r0, issued);
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            a = $urandom; b = $urandom; sub = 1'(i); in_valid = 1'b1;
        end
        step();
        in_valid = 1'b0;
        step();
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL mid_before_reset: got out_valid=%b, required 1", out_valid);
        end
        rst_n = 1'b0;
        q.delete();
        #1;
        n_checks++;
        if ({out_valid, in_ready, sum} !== {1'b0, 1'b1, {W{1'b0}}}) begin
            n_errors++;
            $display("FAIL mid_reset: got ov=%b ir=%b sum=%h, required 0 1 0", out_valid, in_ready, sum);
        end
        step();
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step();
            n_checks++;
            if ({out_valid, in_ready} !== 2'b01) begin
                n_errors++;
                $display("FAIL mid_stale: cycle %0d got ov=%b ir=%b, required 0 1", c, out_valid, in_ready);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_stream();
        test_stall();
        test_sparse();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
